plain_broadcast_split: RTL and testbench
========================================

PLAIN_BROADCAST_SPLIT -- requirements
Module: plain_broadcast_split

Interface
REQ-001 SHALL have parameter T, default 3, number of GF(2^32) words per split (1..8).
REQ-002 SHALL have parameter D_SPLIT, default 2, number of splits processed per run (1..4).
REQ-003 SHALL have parameter M, default 230, evaluator address range; SI_W = max(1, clog2(D_SPLIT)).
REQ-004 SHALL have the port i_clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 SHALL have the port i_rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-006 SHALL have these control ports: i_start in 1 (run request); o_busy out 1; o_done out 1 (end-of-run pulse).
REQ-007 SHALL have these per-split operand ports, all selected externally by o_split_idx: i_eps, i_a and i_b, each in 32*T; word k is bits [32k+31:32k].
REQ-008 SHALL have these evaluator ports: o_start_evaluate out 1; o_sel_q out 1 (1=Q, 0=S); o_split_idx out SI_W; i_evaluate_out in 32*T; i_done_evaluate in 1.
REQ-009 SHALL have these multiplier ports: o_start_mul32 out 1; o_x_mul32 out 32; o_y_mul32 out 32; i_o_mul32 in 32; i_done_mul32 in 1.
REQ-010 SHALL have these result stream ports: o_alpha out 32*T; o_beta out 32*T; o_ab_idx out SI_W; o_ab_valid out 1; i_ab_ready in 1.

Function
REQ-011 SHALL compute, for each split j = 0..D_SPLIT-1 in order: alpha[k] = eps[k]*Q_j(r)[k] XOR a[k], and beta[k] = S_j(r)[k] XOR b[k], for k = 0..T-1.
REQ-012 SHALL perform GF(2^32) addition internally as bitwise XOR; there is no external adder handshake.
REQ-013 SHALL implement FSM states IDLE, EVAL_Q, WAIT_Q, MUL_ISSUE, MUL_WAIT, EVAL_S, WAIT_S, OUT, DONE.
REQ-014 SHALL transition IDLE->EVAL_Q on i_start; i_start SHALL be ignored in every other state.
REQ-015 SHALL, in EVAL_Q and EVAL_S, pulse o_start_evaluate for exactly one cycle, then go to WAIT_Q or WAIT_S respectively.
REQ-016 SHALL hold o_sel_q=1 in EVAL_Q and WAIT_Q, and 0 otherwise.
REQ-017 SHALL keep o_split_idx stable from EVAL_Q through OUT of the same split.
REQ-018 SHALL, on i_done_evaluate in WAIT_Q, capture i_evaluate_out into a work register, reset word counter k to 0, and go to MUL_ISSUE.
REQ-019 SHALL, in MUL_ISSUE, pulse o_start_mul32 for one cycle with o_x_mul32 = work[k] and o_y_mul32 = i_eps word k, then go to MUL_WAIT.
REQ-020 SHALL, on i_done_mul32 in MUL_WAIT, store alpha[k] = i_o_mul32 XOR i_a word k; if k = T-1 go to EVAL_S, else increment k and return to MUL_ISSUE.
REQ-021 SHALL, on i_done_evaluate in WAIT_S, store beta = i_evaluate_out XOR i_b (all words in the same cycle) and go to OUT.
REQ-022 SHALL, in OUT, hold o_ab_valid=1 with o_alpha, o_beta and o_ab_idx stable until i_ab_ready=1; on that handshake go to EVAL_Q for split j+1, or to DONE if j = D_SPLIT-1.
REQ-023 SHALL, when i_ab_ready=1 is already high on OUT entry, complete the transfer in that same cycle.
REQ-024 SHALL, in DONE, pulse o_done for one cycle and return to IDLE; o_busy=1 in every state except IDLE.
REQ-025 SHALL ignore done strobes arriving outside their matching wait state; a stray i_done_mul32 in WAIT_Q SHALL have no effect.
REQ-026 SHALL, with zero-latency evaluator and multiplier responses (done in the cycle after start), have a per-split latency from EVAL_Q to OUT entry of 2+2T+2 cycles.
REQ-027 SHALL, for D_SPLIT=1, go OUT->DONE directly, and o_split_idx SHALL be constant 0.

Reset
REQ-028 SHALL, on i_rst_n=0 and asynchronously, force state to IDLE, j and k to 0, o_alpha, o_beta and the work register to 0, and all strobes, o_busy, o_done and o_ab_valid to 0.
REQ-029 SHALL, on reset asserted mid-run, abandon the run with no o_done pulse; the first i_start after reset release SHALL start at split 0.

Structure
REQ-030 SHALL place the GF word width (32), the FSM state encoding and the SI_W function in the shared sign package.
REQ-031 SHALL use one sub-module, gf32_word_sel, a T-way word multiplexer indexed by k, shared by the work and eps selection paths.

Verification
REQ-032 SHALL cover: T=3, D_SPLIT=1, eps=a=b=0, with Q(r) and S(r) returning 0x1,0x2,0x3 -> alpha=0, beta=0x3_2_1 words, one o_done pulse.
REQ-033 SHALL cover: a=0xFFFFFFFF per word, with a multiplier model returning 0x12345678 -> every alpha word = 0xEDCBA987.
REQ-034 SHALL cover: D_SPLIT=2, i_ab_ready held low 5 cycles in OUT of split 0 -> outputs stable and o_ab_idx=0 throughout; split 1 then starts; exactly 2 transfers.
REQ-035 SHALL cover: i_start pulsed during MUL_WAIT -> no restart; the run completes normally.
REQ-036 SHALL cover: i_rst_n dropped in WAIT_S of split 1 -> all outputs 0 immediately, no o_done; the next run produces the split-0 results.
REQ-037 SHALL cover: zero-latency models with T=3 -> OUT entered exactly 10 cycles after EVAL_Q.

Source files
------------

// File: rtl/plain_broadcast_split_pkg.sv
// Shared definitions for the broadcast-split datapath: GF word width, FSM encoding,
// and the index-width helper used for split and word counters.
package plain_broadcast_split_pkg;

    localparam int unsigned GF_W = 32;

    typedef enum logic [3:0] {
        StIdle,
        StEvalQ,
        StWaitQ,
        StMulIssue,
        StMulWait,
        StEvalS,
        StWaitS,
        StOut,
        StDone
    } state_e;

    // Index width that never collapses to zero for single-entry ranges.
    function automatic int unsigned si_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gf32_word_sel.sv
// T-way GF(2^32) word multiplexer; picks word i_sel out of a packed T-word vector.
module gf32_word_sel
    import plain_broadcast_split_pkg::*;
#(
    parameter int unsigned T = 3,
    localparam int unsigned K_W = si_width(T)
) (
    input  logic [GF_W*T-1:0] i_words,
    input  logic [K_W-1:0]    i_sel,
    output logic [GF_W-1:0]   o_word
);

    always_comb begin
        o_word = '0;
        for (int unsigned k = 0; k < T; k++) begin
            if (i_sel == K_W'(k)) begin
                o_word = i_words[GF_W*k +: GF_W];
            end
        end
    end

endmodule

// File: rtl/plain_broadcast_split.sv
// Per-split alpha/beta generator: alpha = eps*Q(r) XOR a, beta = S(r) XOR b, streamed out
// one split at a time through a valid/ready port, using an external evaluator and multiplier.
module plain_broadcast_split
    import plain_broadcast_split_pkg::*;
#(
    parameter int unsigned T       = 3,
    parameter int unsigned D_SPLIT = 2,
    parameter int unsigned M       = 230,
    localparam int unsigned SI_W   = si_width(D_SPLIT)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,

    input  logic                i_start,
    output logic                o_busy,
    output logic                o_done,

    input  logic [GF_W*T-1:0]   i_eps,
    input  logic [GF_W*T-1:0]   i_a,
    input  logic [GF_W*T-1:0]   i_b,

    output logic                o_start_evaluate,
    output logic                o_sel_q,
    output logic [SI_W-1:0]     o_split_idx,
    input  logic [GF_W*T-1:0]   i_evaluate_out,
    input  logic                i_done_evaluate,

    output logic                o_start_mul32,
    output logic [GF_W-1:0]     o_x_mul32,
    output logic [GF_W-1:0]     o_y_mul32,
    input  logic [GF_W-1:0]     i_o_mul32,
    input  logic                i_done_mul32,

    output logic [GF_W*T-1:0]   o_alpha,
    output logic [GF_W*T-1:0]   o_beta,
    output logic [SI_W-1:0]     o_ab_idx,
    output logic                o_ab_valid,
    input  logic                i_ab_ready
);

    localparam int unsigned     K_W    = si_width(T);
    localparam logic [K_W-1:0]  K_LAST = K_W'(T - 1);
    localparam logic [SI_W-1:0] J_LAST = SI_W'(D_SPLIT - 1);

    if (T < 1 || T > 8) begin : g_bad_t
        $error("plain_broadcast_split: T must be in 1..8");
    end
    if (D_SPLIT < 1 || D_SPLIT > 4) begin : g_bad_d
        $error("plain_broadcast_split: D_SPLIT must be in 1..4");
    end
    if (M < 1) begin : g_bad_m
        $error("plain_broadcast_split: M must be at least 1");
    end

    state_e              r_state;
    state_e              w_state_nxt;
    logic [SI_W-1:0]     r_j;
    logic [K_W-1:0]      r_k;
    logic [GF_W*T-1:0]   r_work;
    logic [GF_W*T-1:0]   r_alpha;
    logic [GF_W*T-1:0]   r_beta;
    logic [GF_W-1:0]     w_work_word;
    logic [GF_W-1:0]     w_eps_word;
    logic                w_last_k;
    logic                w_last_j;

    assign w_last_k = (r_k == K_LAST);
    assign w_last_j = (r_j == J_LAST);

    // Same word index drives both the captured Q(r) and the eps operand paths.
    gf32_word_sel #(
        .T(T)
    ) u_work_sel (
        .i_words (r_work),
        .i_sel   (r_k),
        .o_word  (w_work_word)
    );

    gf32_word_sel #(
        .T(T)
    ) u_eps_sel (
        .i_words (i_eps),
        .i_sel   (r_k),
        .o_word  (w_eps_word)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:     if (i_start) w_state_nxt = StEvalQ;
            StEvalQ:    w_state_nxt = StWaitQ;
            StWaitQ:    if (i_done_evaluate) w_state_nxt = StMulIssue;
            StMulIssue: w_state_nxt = StMulWait;
            StMulWait:  if (i_done_mul32) w_state_nxt = w_last_k ? StEvalS : StMulIssue;
            StEvalS:    w_state_nxt = StWaitS;
            StWaitS:    if (i_done_evaluate) w_state_nxt = StOut;
            StOut:      if (i_ab_ready) w_state_nxt = w_last_j ? StDone : StEvalQ;
            StDone:     w_state_nxt = StIdle;
            default:    w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_j     <= '0;
            r_k     <= '0;
            r_work  <= '0;
            r_alpha <= '0;
            r_beta  <= '0;
        end else begin
            case (r_state)
                StWaitQ: begin
                    if (i_done_evaluate) begin
                        r_work <= i_evaluate_out;
                        r_k    <= '0;
                    end
                end
                StMulWait: begin
                    if (i_done_mul32) begin
                        for (int unsigned k = 0; k < T; k++) begin
                            if (r_k == K_W'(k)) begin
                                r_alpha[GF_W*k +: GF_W] <= i_o_mul32 ^ i_a[GF_W*k +: GF_W];
                            end
                        end
                        if (!w_last_k) begin
                            r_k <= r_k + K_W'(1);
                        end
                    end
                end
                StWaitS: begin
                    if (i_done_evaluate) begin
                        r_beta <= i_evaluate_out ^ i_b;
                    end
                end
                StOut: begin
                    // Split index advances only on the handshake, so it is stable through OUT.
                    if (i_ab_ready) begin
                        r_j <= w_last_j ? '0 : r_j + SI_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy           = (r_state != StIdle);
    assign o_done           = (r_state == StDone);
    assign o_start_evaluate = (r_state == StEvalQ) || (r_state == StEvalS);
    assign o_sel_q          = (r_state == StEvalQ) || (r_state == StWaitQ);
    assign o_split_idx      = r_j;
    assign o_start_mul32    = (r_state == StMulIssue);
    assign o_x_mul32        = w_work_word;
    assign o_y_mul32        = w_eps_word;
    assign o_alpha          = r_alpha;
    assign o_beta           = r_beta;
    assign o_ab_idx         = r_j;
    assign o_ab_valid       = (r_state == StOut);

endmodule

// File: tb/tb_plain_broadcast_split.sv
// Bench for plain_broadcast_split: two instances (D_SPLIT=2 and 1) with behavioural evaluator
// and multiplier responders, a per-cycle alpha/beta scoreboard and directed scenario checks.
module tb_plain_broadcast_split;

    localparam int T = 3;
    localparam int W = 32 * T;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] start_r = '0;
    logic [1:0] ready_r = '1;

    logic [31:0] q_tab   [2][T];
    logic [31:0] s_tab   [2][T];
    logic [31:0] eps_tab [2][T];
    logic [31:0] a_tab   [2][T];
    logic [31:0] b_tab   [2][T];

    int ev_lat = 0;
    int mul_lat = 0;
    bit mul_const = 1'b0;
    bit stray_mul = 1'b0;

    int checks = 0;
    int errors = 0;

    int          exp_j [2] = '{0, 0};
    int          xfers [2] = '{0, 0};
    int          done_cnt [2] = '{0, 0};
    int          evq_cnt [2] = '{0, 0};
    int          lat [2] = '{0, 0};
    int          last_lat [2] = '{0, 0};
    bit          lat_run [2] = '{1'b0, 1'b0};
    logic [W-1:0] last_a [2];
    logic [W-1:0] last_b [2];

    always #5 clk = ~clk;

    // Carry-less product reduced by x^32 + x^7 + x^3 + x^2 + 1.
    function automatic logic [31:0] gf_mul(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] p = '0;
        logic [31:0] a = x;
        for (int i = 0; i < 32; i++) begin
            if (y[i]) p = p ^ a;
            a = a[31] ? ((a << 1) ^ 32'h0000_008D) : (a << 1);
        end
        return p;
    endfunction

    function automatic logic [31:0] mul_model(input logic [31:0] x, input logic [31:0] y);
        return mul_const ? 32'h1234_5678 : gf_mul(x, y);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_i
        localparam int DS = (g == 0) ? 2 : 1;
        logic         busy, done, start_ev, sel_q, start_mul, ab_valid;
        logic         ev_done = 1'b0;
        logic         mul_done = 1'b0;
        logic [0:0]   sidx, ab_idx;
        logic [W-1:0] eps_w, a_w, b_w, alpha, beta;
        logic [W-1:0] ev_out = '0;
        logic [31:0]  x, y;
        logic [31:0]  mul_out = '0;
        int           ev_cnt = 0;
        int           mul_cnt = 0;
        int           ev_j = 0;
        bit           ev_q = 1'b0;
        logic [31:0]  mx = '0;
        logic [31:0]  my = '0;

        always_comb begin
            eps_w = '0;
            a_w   = '0;
            b_w   = '0;
            for (int k = 0; k < T; k++) begin
                eps_w[32*k +: 32] = eps_tab[sidx][k];
                a_w[32*k +: 32]   = a_tab[sidx][k];
                b_w[32*k +: 32]   = b_tab[sidx][k];
            end
        end

        // Evaluator/multiplier: done arrives lat+1 cycles after the start strobe.
        always @(negedge clk) begin
            ev_done  = 1'b0;
            mul_done = 1'b0;
            if (!rst_n) begin
                ev_cnt  = 0;
                mul_cnt = 0;
            end else begin
                if (ev_cnt > 0) begin
                    ev_cnt--;
                    if (ev_cnt == 0) begin
                        ev_done = 1'b1;
                        for (int k = 0; k < T; k++)
                            ev_out[32*k +: 32] = ev_q ? q_tab[ev_j][k] : s_tab[ev_j][k];
                    end
                end
                if (mul_cnt > 0) begin
                    mul_cnt--;
                    if (mul_cnt == 0) begin
                        mul_done = 1'b1;
                        mul_out  = mul_model(mx, my);
                    end
                end else if (stray_mul && sel_q && !start_ev) begin
                    mul_done = 1'b1;
                    mul_out  = 32'hDEAD_BEEF;
                end
                if (start_ev) begin
                    ev_cnt = ev_lat + 1;
                    ev_q   = sel_q;
                    ev_j   = int'(sidx);
                end
                if (start_mul) begin
                    mul_cnt = mul_lat + 1;
                    mx      = x;
                    my      = y;
                end
            end
        end

        plain_broadcast_split #(
            .T       (T),
            .D_SPLIT (DS),
            .M       (230)
        ) u_dut (
            .i_clk            (clk),
            .i_rst_n          (rst_n),
            .i_start          (start_r[g]),
            .o_busy           (busy),
            .o_done           (done),
            .i_eps            (eps_w),
            .i_a              (a_w),
            .i_b              (b_w),
            .o_start_evaluate (start_ev),
            .o_sel_q          (sel_q),
            .o_split_idx      (sidx),
            .i_evaluate_out   (ev_out),
            .i_done_evaluate  (ev_done),
            .o_start_mul32    (start_mul),
            .o_x_mul32        (x),
            .o_y_mul32        (y),
            .i_o_mul32        (mul_out),
            .i_done_mul32     (mul_done),
            .o_alpha          (alpha),
            .o_beta           (beta),
            .o_ab_idx         (ab_idx),
            .o_ab_valid       (ab_valid),
            .i_ab_ready       (ready_r[g])
        );
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: expected split results computed straight from the alpha/beta formulas.
    task automatic sb(input int g, input int ds, input logic [W-1:0] alpha,
                      input logic [W-1:0] beta, input logic idx, input logic valid,
                      input logic ready, input logic done, input logic sev, input logic selq);
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        int j;
        if (!rst_n) begin
            exp_j[g]   = 0;
            lat_run[g] = 1'b0;
            return;
        end
        if (sev && selq) begin
            lat[g]     = 0;
            lat_run[g] = 1'b1;
            evq_cnt[g]++;
        end else if (lat_run[g]) begin
            lat[g]++;
        end
        if (valid) begin
            if (lat_run[g]) begin
                last_lat[g] = lat[g];
                lat_run[g]  = 1'b0;
            end
            j = exp_j[g];
            for (int k = 0; k < T; k++) begin
                ea[32*k +: 32] = mul_model(q_tab[j][k], eps_tab[j][k]) ^ a_tab[j][k];
                eb[32*k +: 32] = s_tab[j][k] ^ b_tab[j][k];
            end
            check($sformatf("alpha%0d_split%0d", g, j), alpha, ea);
            check($sformatf("beta%0d_split%0d", g, j), beta, eb);
            check_int($sformatf("ab_idx%0d", g), int'(idx), j);
            if (ready) begin
                xfers[g]++;
                last_a[g] = alpha;
                last_b[g] = beta;
                exp_j[g]  = (j + 1 == ds) ? 0 : j + 1;
            end
        end
        if (done) done_cnt[g]++;
    endtask

    task automatic cycle();
        @(negedge clk);
        sb(0, 2, g_i[0].alpha, g_i[0].beta, g_i[0].ab_idx[0], g_i[0].ab_valid, ready_r[0],
           g_i[0].done, g_i[0].start_ev, g_i[0].sel_q);
        sb(1, 1, g_i[1].alpha, g_i[1].beta, g_i[1].ab_idx[0], g_i[1].ab_valid, ready_r[1],
           g_i[1].done, g_i[1].start_ev, g_i[1].sel_q);
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int g);
        start_r[g] = 1'b1;
        cycle();
        start_r[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int max);
        int d0 = done_cnt[g];
        for (int i = 0; i < max; i++) begin
            cycle();
            if (done_cnt[g] != d0) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout_done%0d: got no o_done, expected one within %0d cycles", g, max);
    endtask

    function automatic bit cond0(input int which);
        case (which)
            0:       return g_i[0].start_mul;
            1:       return g_i[0].start_ev && !g_i[0].sel_q && (g_i[0].sidx == 1'b1);
            default: return g_i[0].ab_valid;
        endcase
    endfunction

    task automatic wait_dut0(input int which, input int max);
        for (int i = 0; i < max; i++) begin
            if (cond0(which)) return;
            cycle();
        end
        checks++;
        errors++;
        $display("FAIL timeout_cond%0d: got condition false, expected true within %0d", which, max);
    endtask

    task automatic rand_tables(input bit a_ones);
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < T; k++) begin
                q_tab[j][k]   = $urandom();
                s_tab[j][k]   = $urandom();
                eps_tab[j][k] = $urandom();
                b_tab[j][k]   = $urandom();
                a_tab[j][k]   = a_ones ? 32'hFFFF_FFFF : $urandom();
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_strobes0"}, W'({g_i[0].busy, g_i[0].done, g_i[0].start_ev,
              g_i[0].start_mul, g_i[0].ab_valid, g_i[0].sel_q, g_i[0].sidx}), '0);
        check({tag, "_alpha0"}, g_i[0].alpha, '0);
        check({tag, "_beta0"}, g_i[0].beta, '0);
        check({tag, "_strobes1"}, W'({g_i[1].busy, g_i[1].done, g_i[1].start_ev,
              g_i[1].start_mul, g_i[1].ab_valid, g_i[1].sel_q, g_i[1].sidx}), '0);
        check({tag, "_alpha1"}, g_i[1].alpha, '0);
    endtask

    initial begin
        int d_done, d_xf, d_evq;
        rand_tables(1'b0);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("reset");
        cycle();
        rst_n = 1'b1;
        cycle();

        // D_SPLIT=1, zero operands, Q/S = 1,2,3; zero-latency responders.
        for (int k = 0; k < T; k++) begin
            eps_tab[0][k] = '0;
            a_tab[0][k]   = '0;
            b_tab[0][k]   = '0;
            q_tab[0][k]   = 32'(k + 1);
            s_tab[0][k]   = 32'(k + 1);
        end
        start_run(1);
        wait_done(1, 100);
        check("d1_alpha_lit", last_a[1], '0);
        check("d1_beta_lit", last_b[1], 96'h00000003_00000002_00000001);
        check_int("d1_latency", last_lat[1], 10);
        check_int("d1_done_cnt", done_cnt[1], 1);
        check_int("d1_xfers", xfers[1], 1);
        cycle();
        check("d1_idle_after", W'(g_i[1].busy), '0);

        // Constant multiplier with a = all ones.
        rand_tables(1'b1);
        mul_const = 1'b1;
        start_run(0);
        wait_done(0, 200);
        check("const_alpha_lit", last_a[0], {3{32'hEDCB_A987}});
        check_int("const_xfers", xfers[0], 2);
        check_int("const_done_cnt", done_cnt[0], 1);
        check_int("const_latency", last_lat[0], 10);
        check_int("const_evq", evq_cnt[0], 2);
        mul_const = 1'b0;

        // Back-pressure: ready low for 5 cycles in OUT of split 0.
        rand_tables(1'b0);
        ready_r[0] = 1'b0;
        d_done = done_cnt[0];
        d_xf   = xfers[0];
        start_run(0);
        wait_dut0(2, 100);
        repeat (5) cycle();
        check("bp_valid_held", W'(g_i[0].ab_valid), W'(1));
        check("bp_idx_held", W'(g_i[0].ab_idx), '0);
        check_int("bp_no_xfer", xfers[0] - d_xf, 0);
        ready_r[0] = 1'b1;
        wait_done(0, 200);
        check_int("bp_xfers", xfers[0] - d_xf, 2);
        check_int("bp_done", done_cnt[0] - d_done, 1);

        // Start pulse during MUL_WAIT and stray multiplier strobes in WAIT_Q.
        rand_tables(1'b0);
        ev_lat    = 2;
        mul_lat   = 3;
        stray_mul = 1'b1;
        d_done = done_cnt[0];
        d_xf   = xfers[0];
        d_evq  = evq_cnt[0];
        start_run(0);
        wait_dut0(0, 100);
        cycle();
        start_run(0);
        wait_done(0, 300);
        check_int("restart_evq", evq_cnt[0] - d_evq, 2);
        check_int("restart_xfers", xfers[0] - d_xf, 2);
        check_int("restart_done", done_cnt[0] - d_done, 1);
        check("restart_idle", W'(g_i[0].busy), '0);
        stray_mul = 1'b0;
        mul_lat   = 0;

        // Reset in WAIT_S of split 1, then a clean rerun.
        rand_tables(1'b0);
        d_done = done_cnt[0];
        d_xf   = xfers[0];
        start_run(0);
        wait_dut0(1, 200);
        cycle();
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        check_int("midreset_no_done", done_cnt[0] - d_done, 0);
        check_int("midreset_xfers", xfers[0] - d_xf, 1);
        d_done = done_cnt[0];
        d_xf   = xfers[0];
        start_run(0);
        wait_done(0, 300);
        check_int("rerun_xfers", xfers[0] - d_xf, 2);
        check_int("rerun_done", done_cnt[0] - d_done, 1);
        check_int("rerun_exp_j", exp_j[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
